mrt_poly_normalize: RTL and testbench

Sequential carry-propagation engine. It converts a redundant-form Minroot polynomial into a canonical little-endian integer, one coefficient per cycle, LSB first. It is the hardware successor to the bench-side poly-to-int conversion, generalised to 1x and 2x (product-width) polynomials selectable per transaction. It sits at the result port of the Minroot engine and feeds the host readback and checker path.

---
 rtl/mrt_pkg.sv | 34 +++
 rtl/mrt_norm_word_step.sv | 40 ++++
 rtl/mrt_poly_normalize.sv | 172 +++++++++++++++++
 tb/tb_mrt_poly_normalize.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mrt_pkg.sv
// ============================================================================
// Module   : mrt_pkg
// Brief    : Shared Minroot sizing, modulus, polynomial type and normaliser
//            state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mrt_pkg;

  localparam int NumCoeffs = 10;
  localparam int WordBits  = 16;
  localparam int CoeffBits = 20;
  localparam int MaxCoeffs = 2 * NumCoeffs;

  localparam logic [NumCoeffs*WordBits-1:0] Modulus =
    160'h8f3a_1c57_0e91_ffff_2b6d_9e01_7755_aa33_0001_4c2d;

  typedef logic [MaxCoeffs*CoeffBits-1:0] poly_2x_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } norm_state_e;

  // Width of the running carry between coefficient positions.
  function automatic int carry_bits(input int coeff_bits, input int word_bits);
    return coeff_bits - word_bits + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mrt_norm_word_step.sv
// ============================================================================
// Module   : mrt_norm_word_step
// Brief    : One coefficient of carry propagation (coeff + carry -> word,
//            carry); with MRT_NORMALIZE_MOD_CMP_EN also one borrow step of the
//            serial modulus subtract.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mrt_norm_word_step #(
  parameter int WordBits  = 16,
  parameter int CoeffBits = 20,
  parameter int CarryBits = CoeffBits - WordBits + 1
) (
  input  logic [CoeffBits-1:0] coeff,
  input  logic [CarryBits-1:0] carry_in,
  output logic [WordBits-1:0]  word,
  output logic [CarryBits-1:0] carry_out
`ifdef MRT_NORMALIZE_MOD_CMP_EN
  ,
  input  logic [WordBits-1:0]  mod_word,
  input  logic                 borrow_in,
  output logic                 borrow_out
`endif
);

  logic [CoeffBits:0] w_sum;

  // The sum top slice is exactly CarryBits wide, so nothing is dropped.
  assign w_sum     = {1'b0, coeff} + (CoeffBits + 1)'(carry_in);
  assign word      = w_sum[WordBits-1:0];
  assign carry_out = w_sum[CoeffBits:WordBits];

`ifdef MRT_NORMALIZE_MOD_CMP_EN
  assign borrow_out = ({1'b0, word} < ({1'b0, mod_word} + (WordBits + 1)'(borrow_in)));
`endif

endmodule

`default_nettype wire

// File: rtl/mrt_poly_normalize.sv
// ============================================================================
// Module   : mrt_poly_normalize
// Brief    : Serial redundant-polynomial to canonical-integer normaliser,
//            LSB coefficient first, 1x or 2x width per transaction.
//            Optional MRT_NORMALIZE_MOD_CMP_EN adds ge_mod_o (result >= Modulus).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mrt_poly_normalize #(
  parameter int NumCoeffs  = mrt_pkg::NumCoeffs,
  parameter int WordBits   = mrt_pkg::WordBits,
  parameter int CoeffBits  = mrt_pkg::CoeffBits,
  parameter int MaxCoeffs  = 2 * NumCoeffs,
  localparam int CarryBits = mrt_pkg::carry_bits(CoeffBits, WordBits)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic                          mode_2x_i,
  input  logic [MaxCoeffs*CoeffBits-1:0] poly_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [MaxCoeffs*WordBits-1:0] int_o,
  output logic [CarryBits-1:0]          carry_o,
  output logic                          mode_2x_o
`ifdef MRT_NORMALIZE_MOD_CMP_EN
  ,
  output logic                          ge_mod_o
`endif
);

  import mrt_pkg::*;

  localparam int IdxBits = $clog2(MaxCoeffs);
  localparam logic [IdxBits-1:0] c_last_1x = IdxBits'(NumCoeffs - 1);
  localparam logic [IdxBits-1:0] c_last_2x = IdxBits'(MaxCoeffs - 1);

  generate
    if (CoeffBits > 2 * WordBits || CoeffBits < WordBits) begin : g_bad_widths
      $error("mrt_poly_normalize: CoeffBits must lie within [WordBits, 2*WordBits]");
    end
  endgenerate

  norm_state_e                   r_state;
  norm_state_e                   w_state_nxt;
  logic [IdxBits-1:0]            r_idx;
  logic [CarryBits-1:0]          r_carry;
  logic [MaxCoeffs*CoeffBits-1:0] r_poly;
  logic                          r_mode;
  logic [MaxCoeffs*WordBits-1:0] r_int;
  logic [CarryBits-1:0]          r_carry_out;

  logic                          w_accept;
  logic                          w_run;
  logic                          w_last;
  logic [CoeffBits-1:0]          w_coeff;
  logic [WordBits-1:0]           w_word;
  logic [CarryBits-1:0]          w_carry_nxt;

  assign w_coeff = r_poly[int'(r_idx)*CoeffBits +: CoeffBits];
  assign w_last  = (r_idx == (r_mode ? c_last_2x : c_last_1x));

`ifdef MRT_NORMALIZE_MOD_CMP_EN
  logic                r_borrow;
  logic                r_ge;
  logic                w_borrow_nxt;
  logic [WordBits-1:0] w_mod_word;

  // Modulus word for the current index; only meaningful in 1x.
  always_comb begin
    w_mod_word = '0;
    for (int k = 0; k < NumCoeffs; k++) begin
      if (int'(r_idx) == k) w_mod_word = Modulus[k*WordBits +: WordBits];
    end
  end
`endif

  mrt_norm_word_step #(
    .WordBits  (WordBits),
    .CoeffBits (CoeffBits),
    .CarryBits (CarryBits)
  ) u_step (
    .coeff     (w_coeff),
    .carry_in  (r_carry),
    .word      (w_word),
    .carry_out (w_carry_nxt)
`ifdef MRT_NORMALIZE_MOD_CMP_EN
    ,
    .mod_word  (w_mod_word),
    .borrow_in (r_borrow),
    .borrow_out(w_borrow_nxt)
`endif
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    w_accept    = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_run = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx       <= '0;
      r_carry     <= '0;
      r_poly      <= '0;
      r_mode      <= 1'b0;
      r_int       <= '0;
      r_carry_out <= '0;
    end else if (w_accept) begin
      r_idx       <= '0;
      r_carry     <= '0;
      r_poly      <= poly_i;
      r_mode      <= mode_2x_i;
      r_int       <= '0;
      r_carry_out <= '0;
    end else if (w_run) begin
      r_int[int'(r_idx)*WordBits +: WordBits] <= w_word;
      r_carry <= w_carry_nxt;
      r_idx   <= r_idx + IdxBits'(1);
      if (w_last) r_carry_out <= w_carry_nxt;
    end
  end

`ifdef MRT_NORMALIZE_MOD_CMP_EN
  // Result >= Modulus when it overflowed the 1x width or the subtract ended without borrow.
  always_ff @(posedge clk) begin
    if (reset || w_accept) begin
      r_borrow <= 1'b0;
      r_ge     <= 1'b0;
    end else if (w_run) begin
      r_borrow <= w_borrow_nxt;
      if (w_last) r_ge <= !r_mode && ((w_carry_nxt != '0) || !w_borrow_nxt);
    end
  end

  assign ge_mod_o = r_ge;
`endif

  assign int_o     = r_int;
  assign carry_o   = r_carry_out;
  assign mode_2x_o = r_mode;

endmodule

`default_nettype wire

// File: tb/tb_mrt_poly_normalize.sv
// ============================================================================
// Module   : tb_mrt_poly_normalize
// Brief    : Directed self-checking bench for mrt_poly_normalize; covers
//            ge_mod_o when MRT_NORMALIZE_MOD_CMP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mrt_poly_normalize;

  import mrt_pkg::*;

  localparam int CarryBits = carry_bits(CoeffBits, WordBits);
  localparam int IntBits   = MaxCoeffs * WordBits;
  localparam int OneXBits  = NumCoeffs * WordBits;
  localparam int RefBits   = 352;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic                 mode_in;
  poly_2x_t             poly_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [IntBits-1:0]   int_out;
  logic [CarryBits-1:0] carry_out;
  logic                 mode_out;
`ifdef MRT_NORMALIZE_MOD_CMP_EN
  logic                 ge_mod;
`endif

  int num_checks = 0;
  int num_fail   = 0;

  logic [IntBits-1:0]   last_int;
  logic [CarryBits-1:0] last_carry;

  always #5 clk = ~clk;

  mrt_poly_normalize dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .mode_2x_i   (mode_in),
    .poly_i      (poly_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .int_o       (int_out),
    .carry_o     (carry_out),
    .mode_2x_o   (mode_out)
`ifdef MRT_NORMALIZE_MOD_CMP_EN
    ,
    .ge_mod_o    (ge_mod)
`endif
  );

  task automatic check_value(input string tag, input logic [RefBits-1:0] got,
                             input logic [RefBits-1:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain weighted sum of coefficients, no carry chain.
  function automatic logic [RefBits-1:0] poly_to_int(input poly_2x_t p);
    logic [RefBits-1:0] acc = '0;
    for (int i = 0; i < NumCoeffs; i++)
      acc += RefBits'(p[i*CoeffBits +: CoeffBits]) << (WordBits * i);
    return acc;
  endfunction

  function automatic logic [RefBits-1:0] poly_to_int_2x(input poly_2x_t p);
    logic [RefBits-1:0] acc = '0;
    for (int i = 0; i < MaxCoeffs; i++)
      acc += RefBits'(p[i*CoeffBits +: CoeffBits]) << (WordBits * i);
    return acc;
  endfunction

  // Called just after a rising edge with the engine idle; leaves it idle again.
  task automatic do_txn(input string tag, input poly_2x_t p, input logic m, input int hold);
    logic [RefBits-1:0] ref_v;
    logic [IntBits-1:0] snap;
    int n;
    int lat;
    logic stable;
    ref_v = m ? poly_to_int_2x(p) : poly_to_int(p);
    n = m ? MaxCoeffs : NumCoeffs;
    poly_in  = p;
    mode_in  = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check_value({tag, "_latency"}, RefBits'(lat), RefBits'(n + 1));
    if (m) begin
      check_value({tag, "_int"}, RefBits'(int_out), RefBits'(ref_v[IntBits-1:0]));
      check_value({tag, "_carry"}, RefBits'(carry_out), ref_v >> IntBits);
    end else begin
      check_value({tag, "_int"}, RefBits'(int_out), RefBits'(ref_v[OneXBits-1:0]));
      check_value({tag, "_carry"}, RefBits'(carry_out), ref_v >> OneXBits);
    end
    check_value({tag, "_mode"}, RefBits'(mode_out), RefBits'(m));
    check_value({tag, "_in_ready_done"}, RefBits'(in_ready), '0);
    last_int   = int_out;
    last_carry = carry_out;
    snap   = int_out;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (int_out !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) check_value({tag, "_hold_stable"}, RefBits'(stable), RefBits'(1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_value({tag, "_released"}, RefBits'({out_valid, in_ready}), RefBits'(2'b01));
  endtask

  initial begin
    poly_2x_t p;
    logic [IntBits-1:0] exp_int;
    logic [OneXBits-1:0] mv;

    reset     = 1'b1;
    in_valid  = 1'b0;
    mode_in   = 1'b0;
    poly_in   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_in_ready", RefBits'(in_ready), RefBits'(1));
    check_value("rst_out_valid", RefBits'(out_valid), '0);
    check_value("rst_int", RefBits'(int_out), '0);
    check_value("rst_carry", RefBits'(carry_out), '0);
    check_value("rst_mode", RefBits'(mode_out), '0);
`ifdef MRT_NORMALIZE_MOD_CMP_EN
    check_value("rst_ge", RefBits'(ge_mod), '0);
`endif
    reset = 1'b0;

    // Every coefficient 1 -> one set bit per 16-bit word.
    p = '0;
    exp_int = '0;
    for (int i = 0; i < NumCoeffs; i++) begin
      p[i*CoeffBits +: CoeffBits] = CoeffBits'(1);
      exp_int[i*WordBits] = 1'b1;
    end
    do_txn("ones", p, 1'b0, 0);
    check_value("ones_hand_int", RefBits'(last_int), RefBits'(exp_int));
    check_value("ones_hand_carry", RefBits'(last_carry), '0);

    // Only the redundant bit of coefficient 0 set -> word1 = 1.
    p = '0;
    p[CoeffBits-1:0] = CoeffBits'(1) << WordBits;
    do_txn("redund", p, 1'b0, 0);
    check_value("redund_hand_int", RefBits'(last_int), RefBits'(1) << WordBits);

    // All-ones coefficients: final carry is 16, upper half untouched.
    p = '0;
    for (int i = 0; i < MaxCoeffs; i++) p[i*CoeffBits +: CoeffBits] = '1;
    do_txn("allones", p, 1'b0, 0);
    check_value("allones_hand_carry", RefBits'(last_carry), RefBits'(16));
    check_value("allones_upper_zero", RefBits'(last_int) >> OneXBits, '0);
`ifdef MRT_NORMALIZE_MOD_CMP_EN
    check_value("allones_ge", RefBits'(ge_mod), RefBits'(1));
`endif

    // 2x with pseudo-random coefficients.
    p = '0;
    for (int i = 0; i < MaxCoeffs; i++) p[i*CoeffBits +: CoeffBits] = CoeffBits'($urandom);
    do_txn("rand2x", p, 1'b1, 0);
`ifdef MRT_NORMALIZE_MOD_CMP_EN
    check_value("rand2x_ge", RefBits'(ge_mod), '0);
`endif

    // Backpressure: DONE held 50 cycles.
    p = '0;
    for (int i = 0; i < NumCoeffs; i++) p[i*CoeffBits +: CoeffBits] = CoeffBits'($urandom);
    do_txn("hold", p, 1'b0, 50);

    // Reset in the middle of a 2x run.
    p = '0;
    for (int i = 0; i < MaxCoeffs; i++) p[i*CoeffBits +: CoeffBits] = CoeffBits'($urandom | 1);
    poly_in  = p;
    mode_in  = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_value("midrun_busy", RefBits'(in_ready), '0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_value("abort_in_ready", RefBits'(in_ready), RefBits'(1));
    check_value("abort_out_valid", RefBits'(out_valid), '0);
    check_value("abort_int", RefBits'(int_out), '0);
    check_value("abort_carry", RefBits'(carry_out), '0);
    check_value("abort_mode", RefBits'(mode_out), '0);
    do_txn("recover", p, 1'b0, 0);

`ifdef MRT_NORMALIZE_MOD_CMP_EN
    mv = Modulus;
    p = '0;
    for (int i = 0; i < NumCoeffs; i++) p[i*CoeffBits +: CoeffBits] = CoeffBits'(mv[i*WordBits +: WordBits]);
    do_txn("mod_eq", p, 1'b0, 0);
    check_value("mod_eq_ge", RefBits'(ge_mod), RefBits'(1));
    mv = mv - 1'b1;
    p = '0;
    for (int i = 0; i < NumCoeffs; i++) p[i*CoeffBits +: CoeffBits] = CoeffBits'(mv[i*WordBits +: WordBits]);
    do_txn("mod_m1", p, 1'b0, 0);
    check_value("mod_m1_ge", RefBits'(ge_mod), '0);
`else
    mv = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fail);
    $finish;
  end

endmodule

`default_nettype wire
